// File: rtl/store_formatter_if.sv
// Store-path bundle between the pipeline/data memory (master) and the store formatter (slave).
interface store_formatter_if;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        misaligned;
    logic        timeout;

    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be, done, misaligned, timeout
    );

    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be, done, misaligned, timeout
    );
endinterface

// File: rtl/store_formatter.sv
// MEM-stage store formatter: narrows SB/SH/SW data into byte lanes with byte enables
// and runs a registered write handshake to data memory with alignment and ack-timeout checks.
module store_formatter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic clk,
    input logic reset,
    store_formatter_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state;
    logic [CW-1:0] count;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        misaligned;
    logic        timeout;

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        fmt_bad;

    // Lane replication means the memory can pick the addressed lane(s) purely by byte enables.
    always_comb begin
        fmt_wdata = bus.st_data;
        fmt_be    = 4'b1111;
        fmt_bad   = 1'b0;
        case (bus.st_size)
            2'b00: begin
                fmt_wdata = {4{bus.st_data[7:0]}};
                fmt_be    = 4'b0001 << bus.st_addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{bus.st_data[15:0]}};
                fmt_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
                fmt_bad   = bus.st_addr[0];
            end
            2'b10: begin
                fmt_bad   = |bus.st_addr[1:0];
            end
            default: begin
                fmt_bad   = 1'b1;
            end
        endcase
    end

    // An ack on the final allowed cycle takes priority over the timeout abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.st_valid) begin
                        if (fmt_bad) begin
                            misaligned <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_addr  <= {bus.st_addr[31:2], 2'b00};
                            mem_wdata <= fmt_wdata;
                            mem_be    <= fmt_be;
                            count     <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                    end else if (count == LAST_COUNT) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.st_ready   = (state == IDLE);
    assign bus.mem_req    = mem_req;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.mem_be     = mem_be;
    assign bus.done       = done;
    assign bus.misaligned = misaligned;
    assign bus.timeout    = timeout;
endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: table of formatting vectors plus hand-written
// sequences for ack latency, timeout, back-to-back stores and reset during a request.
module tb_store_formatter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    store_formatter_if bus ();

    store_formatter #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        bad;
        logic [31:0] wdata;
        logic [3:0]  be;
    } vec_t;

    vec_t vecs[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic apply_stimulus(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        bus.st_valid = 1'b1;
        bus.st_size  = size;
        bus.st_addr  = addr;
        bus.st_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus.st_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] last_addr;
        logic [31:0] last_wdata;
        logic [3:0]  last_be;
        int          high_cycles;
        int          done_pulses;

        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_size  = 2'b00;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.mem_ack  = 1'b0;

        vecs[0]  = '{2'b00, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 32'hDDDD_DDDD, 4'b1000};
        vecs[1]  = '{2'b01, 32'h0000_2002, 32'h1234_5678, 1'b0, 32'h5678_5678, 4'b1100};
        vecs[2]  = '{2'b01, 32'h0000_2001, 32'h1234_5678, 1'b1, 32'h0, 4'b0000};
        vecs[3]  = '{2'b10, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 4'b1111};
        vecs[4]  = '{2'b11, 32'h0000_4000, 32'h0102_0304, 1'b1, 32'h0, 4'b0000};
        vecs[5]  = '{2'b00, 32'h0000_0000, 32'h1122_3344, 1'b0, 32'h4444_4444, 4'b0001};
        vecs[6]  = '{2'b00, 32'h0000_0005, 32'h0000_00A5, 1'b0, 32'hA5A5_A5A5, 4'b0010};
        vecs[7]  = '{2'b00, 32'h0000_000A, 32'hFFFF_FF7E, 1'b0, 32'h7E7E_7E7E, 4'b0100};
        vecs[8]  = '{2'b01, 32'h0000_0006, 32'hCAFE_F00D, 1'b0, 32'hF00D_F00D, 4'b1100};
        vecs[9]  = '{2'b01, 32'h0000_0008, 32'h9ABC_DEF0, 1'b0, 32'hDEF0_DEF0, 4'b0011};
        vecs[10] = '{2'b10, 32'h0000_3002, 32'h5555_AAAA, 1'b1, 32'h0, 4'b0000};
        vecs[11] = '{2'b10, 32'h0000_3001, 32'h5555_AAAA, 1'b1, 32'h0, 4'b0000};
        vecs[12] = '{2'b01, 32'h0000_3003, 32'h5555_AAAA, 1'b1, 32'h0, 4'b0000};
        vecs[13] = '{2'b11, 32'h0000_4001, 32'h5555_AAAA, 1'b1, 32'h0, 4'b0000};

        repeat (2) @(negedge clk);
        check_output("reset_st_ready", 32'(bus.st_ready), 32'd1);
        check_output("reset_mem_req", 32'(bus.mem_req), 32'd0);
        check_output("reset_mem_addr", bus.mem_addr, 32'h0);
        check_output("reset_mem_wdata", bus.mem_wdata, 32'h0);
        check_output("reset_mem_be", 32'(bus.mem_be), 32'h0);
        check_output("reset_pulses", {29'd0, bus.done, bus.misaligned, bus.timeout}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        last_addr  = 32'h0;
        last_wdata = 32'h0;
        last_be    = 4'h0;
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].size, vecs[i].addr, vecs[i].data);
            if (vecs[i].bad) begin
                check_output($sformatf("v%0d_misaligned", i), 32'(bus.misaligned), 32'd1);
                check_output($sformatf("v%0d_no_req", i), 32'(bus.mem_req), 32'd0);
                check_output($sformatf("v%0d_hold_addr", i), bus.mem_addr, last_addr);
                check_output($sformatf("v%0d_hold_wdata", i), bus.mem_wdata, last_wdata);
                check_output($sformatf("v%0d_hold_be", i), 32'(bus.mem_be), 32'(last_be));
                @(negedge clk);
                check_output($sformatf("v%0d_misaligned_drop", i), 32'(bus.misaligned), 32'd0);
                check_output($sformatf("v%0d_still_no_req", i), 32'(bus.mem_req), 32'd0);
            end else begin
                check_output($sformatf("v%0d_mem_req", i), 32'(bus.mem_req), 32'd1);
                check_output($sformatf("v%0d_st_ready", i), 32'(bus.st_ready), 32'd0);
                check_output($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].addr & 32'hFFFF_FFFC);
                check_output($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
                check_output($sformatf("v%0d_mem_be", i), 32'(bus.mem_be), 32'(vecs[i].be));
                check_output($sformatf("v%0d_no_flags", i), {30'd0, bus.misaligned, bus.timeout}, 32'd0);
                bus.mem_ack = 1'b1;
                @(negedge clk);
                bus.mem_ack = 1'b0;
                check_output($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
                check_output($sformatf("v%0d_req_drop", i), 32'(bus.mem_req), 32'd0);
                check_output($sformatf("v%0d_ready_back", i), 32'(bus.st_ready), 32'd1);
                @(negedge clk);
                check_output($sformatf("v%0d_done_drop", i), 32'(bus.done), 32'd0);
                last_addr  = vecs[i].addr & 32'hFFFF_FFFC;
                last_wdata = vecs[i].wdata;
                last_be    = vecs[i].be;
            end
        end

        // Ack held off five cycles while the pipeline keeps offering another store.
        apply_stimulus(2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
        bus.st_valid = 1'b1;
        bus.st_size  = 2'b00;
        bus.st_addr  = 32'h0000_7001;
        bus.st_data  = 32'h0000_0011;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("hold%0d_req", i), 32'(bus.mem_req), 32'd1);
            check_output($sformatf("hold%0d_addr", i), bus.mem_addr, 32'h0000_3000);
            check_output($sformatf("hold%0d_wdata", i), bus.mem_wdata, 32'hDEAD_BEEF);
            check_output($sformatf("hold%0d_be", i), 32'(bus.mem_be), 32'hF);
            check_output($sformatf("hold%0d_ready", i), 32'(bus.st_ready), 32'd0);
            @(negedge clk);
        end
        bus.st_valid = 1'b0;
        check_output("hold_req_before_ack", 32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_output("hold_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        check_output("hold_no_second_req", 32'(bus.mem_req), 32'd0);

        // Never acknowledged: request must stay up exactly TIMEOUT_CYCLES cycles.
        apply_stimulus(2'b10, 32'h0000_5000, 32'h0BAD_F00D);
        high_cycles = 0;
        for (int i = 0; i < 40 && bus.mem_req; i++) begin
            high_cycles++;
            @(negedge clk);
        end
        check_output("to_high_cycles", 32'(high_cycles), 32'd16);
        check_output("to_timeout", 32'(bus.timeout), 32'd1);
        check_output("to_no_done", 32'(bus.done), 32'd0);
        check_output("to_ready", 32'(bus.st_ready), 32'd1);
        @(negedge clk);
        check_output("to_timeout_drop", 32'(bus.timeout), 32'd0);

        // Ack arriving on the last allowed cycle wins over the timeout.
        apply_stimulus(2'b10, 32'h0000_5004, 32'h1357_9BDF);
        for (int i = 1; i < 16; i++) @(negedge clk);
        check_output("late_ack_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check_output("late_ack_done", 32'(bus.done), 32'd1);
        check_output("late_ack_no_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        check_output("late_ack_no_timeout_after", 32'(bus.timeout), 32'd0);

        // Back-to-back: second store offered in the cycle the first done pulses.
        done_pulses = 0;
        apply_stimulus(2'b10, 32'h0000_6000, 32'h0123_4567);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        if (bus.done) done_pulses++;
        check_output("b2b_ready_on_done", 32'(bus.st_ready), 32'd1);
        apply_stimulus(2'b00, 32'h0000_6001, 32'h0000_0089);
        check_output("b2b_second_req", 32'(bus.mem_req), 32'd1);
        check_output("b2b_second_wdata", bus.mem_wdata, 32'h8989_8989);
        check_output("b2b_second_be", 32'(bus.mem_be), 32'h2);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        if (bus.done) done_pulses++;
        check_output("b2b_done_pulses", 32'(done_pulses), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("stray_ack%0d", i), {30'd0, bus.done, bus.mem_req}, 32'd0);
        end
        bus.mem_ack = 1'b0;

        // Reset while a request is outstanding.
        apply_stimulus(2'b10, 32'h0000_8000, 32'hFEED_FACE);
        check_output("rst_req_before", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_output("rst_req_immediate", 32'(bus.mem_req), 32'd0);
        check_output("rst_ready_immediate", 32'(bus.st_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("rst_no_pulse%0d", i), {28'd0, bus.mem_req, bus.done, bus.misaligned, bus.timeout}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
